// File: rtl/rtc_run_controller.sv
// Run-control sequencer for the RTC time counter: conditions the start/stop/clear
// buttons and drives the counter's start/stop/rst from a registered 4-state FSM.
module rtc_run_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
  parameter int unsigned DB_W            = 21,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk_125MHz,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_clear,
  input  logic             cnt_done,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             cnt_start,
  output logic             cnt_stop,
  output logic             cnt_rst,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lap_value,
  output logic             lap_valid
);

  localparam int unsigned NB = 3;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button bit order: [0] start, [1] stop, [2] clear.
  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync1_d;
  logic [NB-1:0]   sync2_q, sync2_d;
  logic [NB-1:0]   db_q, db_d;
  logic [NB-1:0]   ev_q, ev_d;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];

  logic [1:0]       state_q, state_d;
  logic             cnt_start_q, cnt_start_d;
  logic             cnt_stop_q, cnt_stop_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic [CNT_W-1:0] lap_value_q, lap_value_d;
  logic             lap_valid_q, lap_valid_d;

  logic ev_start, ev_stop, ev_clear;

  assign btn_raw  = {btn_clear, btn_stop, btn_start};
  assign ev_start = ev_q[0];
  assign ev_stop  = ev_q[1];
  assign ev_clear = ev_q[2];

  // Synchronize, debounce and edge-detect each button.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < int'(NB); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
    ev_d = db_d & ~db_q;
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      ev_q    <= '0;
      for (int i = 0; i < int'(NB); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      ev_q    <= ev_d;
      for (int i = 0; i < int'(NB); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; clear overrides everything, then done, then stop, then start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ev_start) state_d = ST_RUN;
      ST_RUN: begin
        if (cnt_done) begin
          state_d = ST_DONE;
        end else if (ev_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (ev_start) state_d = ST_RUN;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (ev_clear) begin
      state_d = ST_IDLE;
    end
  end

  // Outputs decoded from the next state so they land together with it.
  always_comb begin
    cnt_rst_d   = (state_d == ST_IDLE);
    cnt_start_d = (state_d == ST_RUN);
    cnt_stop_d  = (state_d == ST_PAUSE) || (state_d == ST_DONE);
    lap_valid_d = (state_q == ST_RUN) && (state_d == ST_PAUSE);
    lap_value_d = lap_valid_d ? cnt_value : lap_value_q;
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      cnt_rst_q   <= 1'b1;
      cnt_start_q <= 1'b0;
      cnt_stop_q  <= 1'b0;
      lap_valid_q <= 1'b0;
      lap_value_q <= '0;
    end else begin
      cnt_rst_q   <= cnt_rst_d;
      cnt_start_q <= cnt_start_d;
      cnt_stop_q  <= cnt_stop_d;
      lap_valid_q <= lap_valid_d;
      lap_value_q <= lap_value_d;
    end
  end

  assign state     = state_q;
  assign cnt_rst   = cnt_rst_q;
  assign cnt_start = cnt_start_q;
  assign cnt_stop  = cnt_stop_q;
  assign lap_valid = lap_valid_q;
  assign lap_value = lap_value_q;

endmodule
